lamp_ramp_ctrl: RTL and testbench
=================================

Name: lamp_ramp_ctrl

Overview:
- Upstream producer of the 4-bit `active_lights` count consumed by the lamp thermometer decoder (count → 16-bit lamp mask).
- Accepts a requested brightness level over a valid/ready handshake.
- Ramps `active_lights` one step at a time toward the request, one step every STEP_CYCLES clocks, so lamps switch on/off progressively rather than all at once.
- Reports busy and a one-cycle done pulse.

Parameters:
- STEP_CYCLES, 4, clock cycles per ±1 step of active_lights; legal range 1 .. 2^TICK_W-1.
- TICK_W, 8, width of the internal step-tick counter.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request level present.
- req_level  input  4  requested active-lamp count, 0..15.
- req_ready  output  1  block can accept a request this cycle.
- active_lights  output  4  current lamp count; drives the lamp decoder directly, registered.
- busy  output  1  high while ramping (state != IDLE).
- done  output  1  one-cycle pulse when active_lights reaches the accepted target.
- dir_up  output  1  1 while ramping up, 0 otherwise.

Behaviour:
- Reset (async, rst_n=0): active_lights=0, target=0, tick=0, state=IDLE, req_ready=1, busy=0, done=0, dir_up=0.
- Reset is asserted immediately, including mid-ramp; the lamp count drops to 0 with no ramp down.
- Handshake: a request is accepted on a rising edge where req_valid=1 and req_ready=1.
  - req_level is latched into target on that edge.
  - req_level is don't-care when not accepted.
- States: IDLE, RAMP_UP, RAMP_DOWN.
- IDLE, on accept:
  - target > active_lights → RAMP_UP, tick=0, dir_up=1.
  - target < active_lights → RAMP_DOWN, tick=0.
  - target == active_lights → stay IDLE; done=1 in the following cycle.
- RAMP_UP/RAMP_DOWN:
  - tick increments each cycle.
  - When tick == STEP_CYCLES-1: active_lights ±1 and tick returns to 0.
  - On the edge where active_lights becomes equal to target: state → IDLE, busy=0, dir_up=0, and done=1 for exactly that next cycle.
- Latency: first change of active_lights occurs STEP_CYCLES cycles after the accept edge. Full ramp takes |target - start| × STEP_CYCLES cycles.
- STEP_CYCLES=1: one step per clock.
- Arithmetic: 4-bit unsigned. active_lights never wraps, because a step is only taken toward a target in 0..15.
- done is the only pulse output; it is deasserted every cycle it is not explicitly set.
- Back-to-back: in the cycle done=1 the block is IDLE and req_ready=1, so a new request can be accepted in that same cycle.
- Baseline (macro absent): req_ready = (state == IDLE). Requests arriving while busy are held off by the producer.

Optional Feature:
- Macro: LAMP_RAMP_RETARGET_EN.
- Defined:
  - req_ready is tied to 1; requests are accepted in any state.
  - An accept during a ramp replaces target, clears tick, and suppresses any step that would otherwise occur on that edge.
  - The next state is re-evaluated against the current active_lights (may reverse direction, or go to IDLE with a done pulse if equal).
  - Only one done pulse occurs, for the final target.
- Not defined: the baseline behaviour above; requests during a ramp are stalled via req_ready=0.

Test Plan:
- Reset → all outputs 0, req_ready=1. Then request 0 → done pulse one cycle later, active_lights stays 0, busy never asserted.
- STEP_CYCLES=4, from 0 request 5 → busy=1, dir_up=1, active_lights steps 1,2,3,4,5 at cycles 4,8,12,16,20 after accept; done=1 at cycle 20 only; req_ready=0 throughout (baseline).
- From 15 request 3 → steps down every 4 cycles, 48 cycles total, dir_up=0, single done pulse. Then immediately request 15 in the done cycle → accepted, ramps up.
- Reset asserted mid-ramp at active_lights=7 → active_lights=0, state IDLE, busy=0 immediately without waiting for clk; no done pulse.
- STEP_CYCLES=1, 0 → 15 → reaches 15 in 15 cycles; verify no wrap past 15 and no extra step after done.
- LAMP_RAMP_RETARGET_EN: ramping 0→10, at active_lights=6 request 2 → reverses, next step at 4 cycles later to 5, reaches 2 after 16 cycles, one done pulse; request equal to current count mid-ramp → IDLE with done next cycle.

Source files
------------

// File: rtl/lamp_ramp_ctrl.sv
// Ramps active_lights one step per STEP_CYCLES clocks toward a requested level. Latency: first step STEP_CYCLES clocks after accept.
// Backpressure: req_ready low while ramping; define LAMP_RAMP_RETARGET_EN to accept (retarget) in any state.
module lamp_ramp_ctrl #(
    parameter int unsigned STEP_CYCLES = 4,
    parameter int unsigned TICK_W      = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic [3:0] req_level,
    output logic       req_ready,
    output logic [3:0] active_lights,
    output logic       busy,
    output logic       done,
    output logic       dir_up
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2
    } state_t;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(STEP_CYCLES - 1);

    state_t              state_q, state_d;
    logic [3:0]          lights_q, lights_d;
    logic [3:0]          target_q, target_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic                done_q, done_d;
    logic                accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            lights_q <= 4'd0;
            target_q <= 4'd0;
            tick_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lights_q <= lights_d;
            target_q <= target_d;
            tick_q   <= tick_d;
            done_q   <= done_d;
        end
    end

`ifdef LAMP_RAMP_RETARGET_EN
    assign req_ready = 1'b1;
`else
    assign req_ready = (state_q == IDLE);
`endif

    assign accept = req_valid && req_ready;

    always_comb begin
        state_d  = state_q;
        lights_d = lights_q;
        target_d = target_q;
        tick_d   = tick_q;
        done_d   = 1'b0;

        if (state_q == RAMP_UP || state_q == RAMP_DOWN) begin
            if (tick_q == TICK_LAST) begin
                tick_d   = '0;
                lights_d = (state_q == RAMP_UP) ? lights_q + 4'd1 : lights_q - 4'd1;
                if (lights_d == target_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end else begin
                tick_d = tick_q + 1'b1;
            end
        end

        // A new request overrides any step due on this edge and re-plans from the current count.
        if (accept) begin
            target_d = req_level;
            tick_d   = '0;
            lights_d = lights_q;
            done_d   = (req_level == lights_q);
            if (req_level > lights_q) begin
                state_d = RAMP_UP;
            end else if (req_level < lights_q) begin
                state_d = RAMP_DOWN;
            end else begin
                state_d = IDLE;
            end
        end
    end

    assign active_lights = lights_q;
    assign busy          = (state_q != IDLE);
    assign dir_up        = (state_q == RAMP_UP);
    assign done          = done_q;

endmodule

// File: tb/tb_lamp_ramp_ctrl.sv
`timescale 1ns/1ps
module tb_lamp_ramp_ctrl;

    localparam int STEP_A = 4;
    localparam int K_IDLE = 1 << 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a_vld, b_vld;
    logic [3:0] a_lvl, b_lvl;
    logic       a_rdy, b_rdy, a_busy, b_busy, a_done, b_done, a_dir, b_dir;
    logic [3:0] a_act, b_act;

    always #5 clk = ~clk;

    lamp_ramp_ctrl #(.STEP_CYCLES(STEP_A), .TICK_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(a_vld), .req_level(a_lvl),
        .req_ready(a_rdy), .active_lights(a_act), .busy(a_busy), .done(a_done), .dir_up(a_dir)
    );

    lamp_ramp_ctrl #(.STEP_CYCLES(1), .TICK_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(b_vld), .req_level(b_lvl),
        .req_ready(b_rdy), .active_lights(b_act), .busy(b_busy), .done(b_done), .dir_up(b_dir)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference for dut_a: a ramp is a closed-form function of (start, target, edges since accept).
    int m_start, m_tgt, m_k;
    int a_done_cnt;
    bit a_busy_seen;

    function automatic int m_dist();
        return (m_tgt > m_start) ? m_tgt - m_start : m_start - m_tgt;
    endfunction

    function automatic int m_cur();
        int s;
        s = m_k / STEP_A;
        if (s > m_dist()) s = m_dist();
        return (m_tgt >= m_start) ? m_start + s : m_start - s;
    endfunction

    function automatic bit m_busy();
        return m_k < m_dist() * STEP_A;
    endfunction

    function automatic bit m_done();
        return m_k == m_dist() * STEP_A;
    endfunction

    function automatic bit m_dir();
        return m_busy() && (m_tgt > m_start);
    endfunction

    function automatic bit m_ready();
`ifdef LAMP_RAMP_RETARGET_EN
        return 1'b1;
`else
        return !m_busy();
`endif
    endfunction

    task automatic m_reset();
        m_start = 0;
        m_tgt   = 0;
        m_k     = K_IDLE;
    endtask

    task automatic cycle_a(input bit vld, input logic [3:0] lvl);
        bit acc;
        int cur0;
        acc   = vld && m_ready();
        cur0  = m_cur();
        a_vld = vld;
        a_lvl = lvl;
        @(posedge clk);
        if (acc) begin
            m_start = cur0;
            m_tgt   = int'(lvl);
            m_k     = 0;
        end else if (m_k < K_IDLE) begin
            m_k++;
        end
        #1;
        chk("a_active_lights", a_act, m_cur());
        chk("a_busy", a_busy, m_busy());
        chk("a_done", a_done, m_done());
        chk("a_dir_up", a_dir, m_dir());
        chk("a_req_ready", a_rdy, m_ready());
        if (a_done) a_done_cnt++;
        if (a_busy) a_busy_seen = 1'b1;
        a_vld = 1'b0;
    endtask

    task automatic idle_a(input int n);
        for (int i = 0; i < n; i++) cycle_a(1'b0, 4'd0);
    endtask

    typedef struct {
        bit         vld;
        logic [3:0] lvl;
        logic [3:0] e_act;
        bit         e_busy;
        bit         e_done;
        bit         e_dir;
        bit         e_rdy;
    } vec_t;

    vec_t tbl[24];
    bit   ret_en;

    function automatic vec_t mk(bit vld, int lvl, int act, bit bsy, bit dn, bit dir, bit rdy);
        vec_t v;
        v.vld = vld; v.lvl = 4'(lvl); v.e_act = 4'(act);
        v.e_busy = bsy; v.e_done = dn; v.e_dir = dir; v.e_rdy = rdy;
        return v;
    endfunction

    initial begin
`ifdef LAMP_RAMP_RETARGET_EN
        ret_en = 1'b1;
`else
        ret_en = 1'b0;
`endif
        // STEP_CYCLES=1: 0 -> 15, hold, equal request, then 15 -> 12
        tbl[0] = mk(1, 15, 0, 1, 0, 1, ret_en);
        for (int i = 1; i <= 15; i++)
            tbl[i] = mk(0, 0, i, i < 15, i == 15, i < 15, ret_en || (i == 15));
        tbl[16] = mk(0, 0, 15, 0, 0, 0, 1);
        tbl[17] = mk(0, 0, 15, 0, 0, 0, 1);
        tbl[18] = mk(1, 15, 15, 0, 1, 0, 1);
        tbl[19] = mk(1, 12, 15, 1, 0, 0, ret_en);
        tbl[20] = mk(0, 0, 14, 1, 0, 0, ret_en);
        tbl[21] = mk(0, 0, 13, 1, 0, 0, ret_en);
        tbl[22] = mk(0, 0, 12, 0, 1, 0, 1);
        tbl[23] = mk(0, 0, 12, 0, 0, 0, 1);

        rst_n = 1'b0;
        a_vld = 1'b0; a_lvl = 4'd0;
        b_vld = 1'b0; b_lvl = 4'd0;
        a_done_cnt = 0;
        a_busy_seen = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_active", a_act, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_dir", a_dir, 0);
        chk("rst_ready", a_rdy, 1);
        chk("rst_b_active", b_act, 0);
        rst_n = 1'b1;

        // Request equal to current count
        cycle_a(1'b1, 4'd0);
        chk("eq0_done", a_done, 1);
        cycle_a(1'b0, 4'd0);
        chk("eq0_done_clear", a_done, 0);
        chk("eq0_active", a_act, 0);
        chk("eq0_busy_never", a_busy_seen, 0);

        // 0 -> 5 with STEP_CYCLES=4
        a_done_cnt = 0;
        cycle_a(1'b1, 4'd5);
        for (int k = 1; k <= 20; k++) begin
            cycle_a(1'b0, 4'd0);
            if (k % 4 == 0) chk("up5_step", a_act, k / 4);
        end
        chk("up5_final_done", a_done, 1);
        chk("up5_done_count", a_done_cnt, 1);
        idle_a(2);

        // 5 -> 15, then 15 -> 3, then 15 requested in the done cycle
        cycle_a(1'b1, 4'd15);
        idle_a(40);
        chk("up15_active", a_act, 15);
        a_done_cnt = 0;
        cycle_a(1'b1, 4'd3);
        idle_a(48);
        chk("dn3_active", a_act, 3);
        chk("dn3_done", a_done, 1);
        chk("dn3_done_count", a_done_cnt, 1);
        cycle_a(1'b1, 4'd15);
        chk("b2b_busy", a_busy, 1);
        chk("b2b_dir", a_dir, 1);
        idle_a(48);

        // Table-driven STEP_CYCLES=1 run
        for (int i = 0; i < 24; i++) begin
            b_vld = tbl[i].vld;
            b_lvl = tbl[i].lvl;
            @(posedge clk);
            #1;
            chk($sformatf("b_vec%0d_active", i), b_act, tbl[i].e_act);
            chk($sformatf("b_vec%0d_busy", i), b_busy, tbl[i].e_busy);
            chk($sformatf("b_vec%0d_done", i), b_done, tbl[i].e_done);
            chk($sformatf("b_vec%0d_dir", i), b_dir, tbl[i].e_dir);
            chk($sformatf("b_vec%0d_ready", i), b_rdy, tbl[i].e_rdy);
            b_vld = 1'b0;
        end

        // Asynchronous reset mid-ramp at active_lights = 7
        cycle_a(1'b1, 4'd0);
        idle_a(32);
        chk("pre_rst_active", a_act, 7);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_active", a_act, 0);
        chk("arst_busy", a_busy, 0);
        chk("arst_done", a_done, 0);
        chk("arst_ready", a_rdy, 1);
        chk("arst_dir", a_dir, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_reset();
        a_done_cnt = 0;
        idle_a(4);
        chk("arst_no_done", a_done_cnt, 0);

        // Randomized traffic against the reference
        for (int i = 0; i < 1500; i++)
            cycle_a($urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)));
        idle_a(70);

`ifdef LAMP_RAMP_RETARGET_EN
        cycle_a(1'b1, 4'd0);
        idle_a(70);
        cycle_a(1'b1, 4'd10);
        idle_a(24);
        chk("rt_at6", a_act, 6);
        a_done_cnt = 0;
        cycle_a(1'b1, 4'd2);
        idle_a(3);
        chk("rt_hold6", a_act, 6);
        cycle_a(1'b0, 4'd0);
        chk("rt_first_down", a_act, 5);
        chk("rt_dir_down", a_dir, 0);
        idle_a(12);
        chk("rt_reach2", a_act, 2);
        chk("rt_done", a_done, 1);
        chk("rt_done_count", a_done_cnt, 1);
        cycle_a(1'b1, 4'd9);
        idle_a(8);
        chk("rt_at4", a_act, 4);
        cycle_a(1'b1, 4'd4);
        chk("rt_eq_done", a_done, 1);
        chk("rt_eq_busy", a_busy, 0);
        cycle_a(1'b0, 4'd0);
        chk("rt_eq_done_clear", a_done, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
